emu_trace_arbiter: RTL and testbench
====================================

EMU_TRACE_ARBITER -- requirements
Module: emu_trace_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of trace requesters; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32, trace payload width per requester.
REQ-003 Local constant ID_WIDTH SHALL be clog2(NUM_PORTS).
REQ-004 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port pause  input  1  when high, no new grant is issued.
REQ-007 Port in_valid  input  NUM_PORTS  per-requester trace valid.
REQ-008 Port in_ready  output  NUM_PORTS  per-requester trace ready.
REQ-009 Port in_data  input  NUM_PORTS*DATA_WIDTH  requester i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port out_valid  output  1  merged trace valid.
REQ-011 Port out_ready  input  1  merged trace ready from the trace sink.
REQ-012 Port out_data  output  DATA_WIDTH  payload of the granted requester.
REQ-013 Port out_id  output  ID_WIDTH  index of the requester that produced out_data.
REQ-014 Port out_ts  output  64  cycle timestamp of acceptance; present only with EMU_TRACE_ARB_TS_EN.

Function
REQ-015 The output SHALL be a single-entry register stage (slot) holding out_valid, out_data, out_id and out_ts.
REQ-016 The slot is free in a cycle when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-017 The grant SHALL be one-hot combinational: the first i with in_valid[i]=1, searching from rr_ptr upward modulo NUM_PORTS; no grant if pause=1, rst=1, or the slot is not free.
REQ-018 in_ready[i] SHALL be 1 only for the granted i; all other bits are 0. Zero-valid-based grant never occurs, so in_ready never asserts for an idle port.
REQ-019 A transfer on port i occurs when in_valid[i] and in_ready[i]; next edge loads slot with in_data[i], out_id=i, out_valid=1 (latency one cycle).
REQ-020 On a transfer from port g, rr_ptr SHALL become g+1, wrapping to 0 when g=NUM_PORTS-1 (including non-power-of-2 NUM_PORTS); otherwise rr_ptr is held.
REQ-021 Simultaneous drain and load in one cycle SHALL keep out_valid=1 with the new content; no bubble, full throughput one beat per cycle.
REQ-022 Drain without load SHALL clear out_valid on the next edge.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_id, out_ts SHALL remain stable.
REQ-024 pause asserted with a full slot SHALL NOT affect draining of the slot.
REQ-025 With all requesters continuously valid, each port SHALL receive exactly one grant in every NUM_PORTS consecutive transfers.

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, out_data=0, out_id=0, out_ts=0, rr_ptr=0, timestamp counter=0.
REQ-027 During rst=1 all in_ready bits SHALL be 0; a slot entry pending at reset is discarded, not delivered.

Configuration
REQ-028 Macro EMU_TRACE_ARB_TS_EN: when defined, a 64-bit free-running cycle counter increments each non-reset cycle (wrapping at 2^64) and its value at the transfer cycle is loaded into out_ts.
REQ-029 When EMU_TRACE_ARB_TS_EN is undefined, out_ts and the counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 NUM_PORTS=4, all in_valid=1 from reset release, out_ready=1 -> out_id sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1 after first beat.
REQ-031 in_valid=4'b1010, rr_ptr=2, out_ready=1 -> grants 3 then 1 then 3; in_ready[0] and in_ready[2] never 1.
REQ-032 Slot full with data 0xDEADBEEF, out_ready=0 for 5 cycles with all in_valid=1 -> out_data held 0xDEADBEEF, in_ready=0 throughout; first cycle out_ready=1 -> next beat loaded in same cycle, out_valid stays 1.
REQ-033 NUM_PORTS=3, only port 2 valid -> granted, rr_ptr wraps to 0; next transfer from port 0 when ports 0 and 2 valid.
REQ-034 pause=1 with slot full and out_ready=1 -> slot drains, out_valid falls next cycle, no new grant until pause=0.
REQ-035 With EMU_TRACE_ARB_TS_EN, reset released at cycle 0, port 1 transfers at cycle 10 -> out_ts=10; rst pulsed while out_valid=1 -> out_valid=0 next cycle, entry never handshaken.

Source files
------------

// File: rtl/emu_trace_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : emu_trace_arbiter
// Purpose  : Round-robin N:1 trace merger feeding a single-entry output slot.
//            Optional 64-bit acceptance timestamp: EMU_TRACE_ARB_TS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module emu_trace_arbiter #(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pause,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [ID_WIDTH-1:0]             out_id
`ifdef EMU_TRACE_ARB_TS_EN
    ,
    output logic [63:0]                     out_ts
`endif
);

    localparam logic [ID_WIDTH:0]   C_NUM     = (ID_WIDTH+1)'(NUM_PORTS);
    localparam logic [ID_WIDTH-1:0] C_LAST_ID = ID_WIDTH'(NUM_PORTS - 1);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q,    out_id_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q,    rr_ptr_d;

    logic                  w_slot_free;
    logic                  w_can_grant;
    logic                  w_found;
    logic                  w_xfer;
    logic [ID_WIDTH-1:0]   w_gnt_idx;
    logic [ID_WIDTH:0]     w_pos;
    logic [NUM_PORTS-1:0]  w_grant;
    logic [DATA_WIDTH-1:0] w_sel_data;

    assign w_slot_free = ~out_valid_q | out_ready;
    assign w_can_grant = w_slot_free & ~pause & ~rst;

    // Scan from rr_ptr upward; the extra bit in w_pos lets the sum exceed
    // NUM_PORTS before folding back, so non-power-of-2 counts wrap correctly.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_pos     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_pos = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
            if (w_pos >= C_NUM) begin
                w_pos = w_pos - C_NUM;
            end
            if (!w_found && in_valid[w_pos[ID_WIDTH-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_pos[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_can_grant && w_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign w_xfer     = |w_grant;
    assign in_ready   = w_grant;
    assign w_sel_data = in_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // A load takes priority over a drain, giving back-to-back beats with no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_id_d    = w_gnt_idx;
            rr_ptr_d    = (w_gnt_idx == C_LAST_ID) ? '0 : w_gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef EMU_TRACE_ARB_TS_EN
    logic [63:0] ts_cnt_q;
    logic [63:0] out_ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_q <= '0;
            out_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 64'd1;
            if (w_xfer) begin
                out_ts_q <= ts_cnt_q;
            end
        end
    end

    assign out_ts = out_ts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_emu_trace_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_trace_arbiter
// Purpose  : Scenario tasks plus randomized traffic against a round-robin
//            reference model; 4-port and 3-port instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emu_trace_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         pause;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;

    logic         pause3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [23:0]  in_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [7:0]   out_data3;
    logic [1:0]   out_id3;
`ifdef EMU_TRACE_ARB_TS_EN
    logic [63:0]  out_ts;
    logic [63:0]  out_ts3;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (what the output slot should hold)
    logic            m_valid;
    logic [31:0]     m_data;
    int              m_id;
    int              m_rr;
    longint unsigned m_cnt;
    longint unsigned m_ts;

    always #5 clk = ~clk;

    emu_trace_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef EMU_TRACE_ARB_TS_EN
        ,
        .out_ts    (out_ts)
`endif
    );

    emu_trace_arbiter #(.NUM_PORTS(3), .DATA_WIDTH(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_id    (out_id3)
`ifdef EMU_TRACE_ARB_TS_EN
        ,
        .out_ts    (out_ts3)
`endif
    );

    // Winner = first valid port at or after the round-robin pointer, modulo 4
    function automatic int model_gnt();
        if (pause || rst || (m_valid && !out_ready)) return -1;
        for (int k = 0; k < 4; k++)
            if (in_valid[(m_rr + k) % 4]) return (m_rr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] model_rdy();
        int g;
        g = model_gnt();
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    task automatic rand_data();
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_data3 = 24'($urandom);
    endtask

    // Advance one clock; model follows the same edge. Ends 1ns after the edge.
    task automatic tick();
        int g;
        g = model_gnt();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_rr = 0; m_cnt = 0; m_ts = 0;
        end else begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*32 +: 32];
                m_id    = g;
                m_ts    = m_cnt;
                m_rr    = (g + 1) % 4;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pause = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        pause3 = 1'b0; in_valid3 = 3'b111; out_ready3 = 1'b1;
        rand_data();
        repeat (3) begin
            #1;
            n_vec++;
            if (in_ready !== 4'b0 || in_ready3 !== 3'b0) begin
                n_err++; $display("FAIL reset_ready: got %b/%b expected 0", in_ready, in_ready3);
            end
            tick();
        end
        n_vec++;
        if ({out_valid, out_data, out_id} !== 35'b0) begin
            n_err++; $display("FAIL reset_state: got v=%b d=%h id=%0d expected zeros", out_valid, out_data, out_id);
        end
`ifdef EMU_TRACE_ARB_TS_EN
        n_vec++;
        if (out_ts !== 64'd0) begin
            n_err++; $display("FAIL reset_ts: got %0d expected 0", out_ts);
        end
`endif
        in_valid3 = 3'b000;
    endtask

    task automatic test_round_robin();
        rst = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            #1;
            n_vec++;
            if (in_ready !== 4'(1 << (k % 4))) begin
                n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << (k % 4)));
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_data !== m_data) begin
                n_err++; $display("FAIL rr_beat[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                                  k, out_valid, out_id, out_data, k % 4, m_data);
            end
        end
    endtask

    task automatic test_skip();
        int exp_ids[3] = '{3, 1, 3};
        in_valid = 4'b0010; rand_data();
        tick();
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            #1;
            n_vec++;
            if (in_ready !== 4'(1 << exp_ids[k])) begin
                n_err++; $display("FAIL skip_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << exp_ids[k]));
            end
            tick();
            n_vec++;
            if (out_id !== 2'(exp_ids[k]) || out_valid !== 1'b1) begin
                n_err++; $display("FAIL skip_id[%0d]: got %0d expected %0d", k, out_id, exp_ids[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 4'hF; out_ready = 1'b1;
        in_data = {4{32'hDEADBEEF}};
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            #1;
            n_vec++;
            if (in_ready !== 4'b0 || out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
                n_err++; $display("FAIL hold[%0d]: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=deadbeef",
                                  k, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1; rand_data();
        #1;
        n_vec++;
        if (in_ready !== model_rdy() || in_ready === 4'b0) begin
            n_err++; $display("FAIL release_ready: got %b expected %b", in_ready, model_rdy());
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== m_data) begin
            n_err++; $display("FAIL release_beat: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, m_data);
        end
    endtask

    task automatic test_pause();
        pause = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if (in_ready !== 4'b0) begin
                n_err++; $display("FAIL pause_ready[%0d]: got %b expected 0", k, in_ready);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL pause_drain[%0d]: got %b expected 0", k, out_valid);
            end
        end
        pause = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== model_rdy() || in_ready === 4'b0) begin
            n_err++; $display("FAIL unpause_ready: got %b expected %b", in_ready, model_rdy());
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL unpause_beat: got %b expected 1", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 4'hF; out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0) begin
            n_err++; $display("FAIL midrst_ready: got %b expected 0", in_ready);
        end
        tick();
        rst = 1'b0; in_valid = 4'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL midrst_discard[%0d]: got %b expected 0", k, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_wrap3();
        in_valid3 = 3'b100; out_ready3 = 1'b1; rand_data();
        #1;
        n_vec++;
        if (in_ready3 !== 3'b100) begin
            n_err++; $display("FAIL wrap3_ready0: got %b expected 100", in_ready3);
        end
        tick();
        n_vec++;
        if (out_id3 !== 2'd2 || out_data3 !== in_data3[23:16]) begin
            n_err++; $display("FAIL wrap3_beat0: got id=%0d d=%h expected id=2 d=%h", out_id3, out_data3, in_data3[23:16]);
        end
        in_valid3 = 3'b101;
        #1;
        n_vec++;
        if (in_ready3 !== 3'b001) begin
            n_err++; $display("FAIL wrap3_ready1: got %b expected 001", in_ready3);
        end
        tick();
        n_vec++;
        if (out_id3 !== 2'd0 || out_valid3 !== 1'b1) begin
            n_err++; $display("FAIL wrap3_beat1: got id=%0d v=%b expected id=0 v=1", out_id3, out_valid3);
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_fairness();
        int ids[$];
        logic [3:0] mask;
        in_valid = 4'hF; pause = 1'b0;
        for (int c = 0; c < 200; c++) begin
            out_ready = ($urandom_range(0, 3) != 0); rand_data();
            #1;
            n_vec++;
            if (in_ready !== model_rdy()) begin
                n_err++; $display("FAIL fair_ready[%0d]: got %b expected %b", c, in_ready, model_rdy());
            end
            for (int p = 0; p < 4; p++)
                if (in_ready[p] && in_valid[p]) ids.push_back(p);
            tick();
        end
        for (int i = 3; i < ids.size(); i++) begin
            mask = 4'b0;
            for (int j = 0; j < 4; j++) mask |= 4'(1 << ids[i-j]);
            n_vec++;
            if (mask !== 4'hF) begin
                n_err++; $display("FAIL fair_window[%0d]: got ports %b expected 1111", i, mask);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            pause     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = 4'($urandom);
            rand_data();
            #1;
            n_vec++;
            if (in_ready !== model_rdy() || out_valid !== m_valid) begin
                n_err++; $display("FAIL rand_ctl[%0d]: got rdy=%b v=%b expected rdy=%b v=%b",
                                  c, in_ready, out_valid, model_rdy(), m_valid);
            end
            if (m_valid) begin
                n_vec++;
                if (out_data !== m_data || out_id !== 2'(m_id)) begin
                    n_err++; $display("FAIL rand_slot[%0d]: got d=%h id=%0d expected d=%h id=%0d",
                                      c, out_data, out_id, m_data, m_id);
                end
`ifdef EMU_TRACE_ARB_TS_EN
                n_vec++;
                if (out_ts !== m_ts) begin
                    n_err++; $display("FAIL rand_ts[%0d]: got %0d expected %0d", c, out_ts, m_ts);
                end
`endif
            end
            tick();
        end
        rst = 1'b0; pause = 1'b0;
    endtask

`ifdef EMU_TRACE_ARB_TS_EN
    task automatic test_timestamp();
        rst = 1'b1; in_valid = 4'b0; out_ready = 1'b1; pause = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        in_valid = 4'b0010; rand_data();
        tick();
        n_vec++;
        if (out_ts !== 64'd10 || out_id !== 2'd1 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL ts_value: got ts=%0d id=%0d v=%b expected ts=10 id=1 v=1", out_ts, out_id, out_valid);
        end
        in_valid = 4'b0;
    endtask
`endif

    initial begin
        m_valid = 1'b0; m_data = '0; m_id = 0; m_rr = 0; m_cnt = 0; m_ts = 0;
        in_data = '0; in_data3 = '0;
        test_reset();
        test_round_robin();
        test_skip();
        test_backpressure();
        test_pause();
        test_reset_mid();
        test_wrap3();
        test_fairness();
        test_random();
`ifdef EMU_TRACE_ARB_TS_EN
        test_timestamp();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
